// File: rtl/car_controller_if.sv
// Handshake bundle between the car controller and its datapath: event pulses
// and status flags in, per-state control strobes and debug state out.
interface car_controller_if;
    logic       start;
    logic       frame_tick;
    logic       destroyed;
    logic       initial_delay_done;
    logic       draw_done;
    logic       erase_done;
    logic       game_over;

    logic       wait_start;
    logic       delay;
    logic       draw_car;
    logic       draw_wait;
    logic       erase_car;
    logic       increment;
    logic       destroyed_state;
    logic       car_active;
    logic [2:0] state;

    // The controller is the slave: it consumes events and flags and drives strobes.
    modport slave (
        input  start, frame_tick, destroyed, initial_delay_done, draw_done, erase_done, game_over,
        output wait_start, delay, draw_car, draw_wait, erase_car, increment, destroyed_state,
        output car_active, state
    );

    modport master (
        output start, frame_tick, destroyed, initial_delay_done, draw_done, erase_done, game_over,
        input  wait_start, delay, draw_car, draw_wait, erase_car, increment, destroyed_state,
        input  car_active, state
    );
endinterface

// File: rtl/car_controller.sv
// Moore FSM sequencing one car through delay, draw/wait/erase/step cycles,
// with deferred kill handling so a sprite is never left half drawn.
module car_controller #(
    parameter int unsigned MOVE_FRAMES = 1
) (
    input  logic              clk,
    input  logic              resetn,
    car_controller_if.slave   bus
);
    typedef enum logic [2:0] {
        S_WAIT_START = 3'd0,
        S_DELAY      = 3'd1,
        S_DRAW       = 3'd2,
        S_DRAW_WAIT  = 3'd3,
        S_ERASE      = 3'd4,
        S_INCREMENT  = 3'd5,
        S_DESTROYED  = 3'd6,
        S_GAME_OVER  = 3'd7
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] frame_cnt;
    logic [8:0] frame_cnt_next;
    logic       move_due;
    logic       pending_kill;
    logic       kill_window;

    // The move is due on the edge where the tick takes the counter to MOVE_FRAMES.
    assign frame_cnt_next = {1'b0, frame_cnt} + {8'd0, bus.frame_tick};
    assign move_due       = (frame_cnt_next == 9'(MOVE_FRAMES));
    assign kill_window    = (state == S_DRAW) || (state == S_DRAW_WAIT) ||
                            (state == S_ERASE) || (state == S_INCREMENT);

    always_comb begin
        // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
        next_state = state;
        unique case (state)
            S_WAIT_START: if (bus.start) next_state = S_DELAY;
            S_DELAY: begin
                if (bus.destroyed)               next_state = S_DESTROYED;
                else if (bus.initial_delay_done) next_state = S_DRAW;
            end
            S_DRAW:       if (bus.draw_done) next_state = S_DRAW_WAIT;
            S_DRAW_WAIT: begin
                if (bus.game_over)      next_state = S_GAME_OVER;
                else if (pending_kill)  next_state = S_ERASE;
                else if (move_due)      next_state = S_ERASE;
            end
            S_ERASE: begin
                if (bus.erase_done) next_state = pending_kill ? S_DESTROYED : S_INCREMENT;
            end
            S_INCREMENT:  next_state = S_DRAW;
            S_DESTROYED,
            S_GAME_OVER:  if (bus.start) next_state = S_WAIT_START;
            default:      next_state = S_WAIT_START;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_WAIT_START;
            frame_cnt    <= 8'd0;
            pending_kill <= 1'b0;
        end else begin
            state <= next_state;

            if ((next_state == S_DRAW_WAIT) && (state != S_DRAW_WAIT))
                frame_cnt <= 8'd0;
            else if ((state == S_DRAW_WAIT) && bus.frame_tick)
                frame_cnt <= frame_cnt_next[7:0];

            // A kill is remembered until the car is gone or the game re-arms.
            if ((next_state == S_DESTROYED) || (next_state == S_WAIT_START))
                pending_kill <= 1'b0;
            else if (bus.destroyed && kill_window)
                pending_kill <= 1'b1;
        end
    end

    assign bus.wait_start      = (state == S_WAIT_START);
    assign bus.delay           = (state == S_DELAY);
    assign bus.draw_car        = (state == S_DRAW);
    assign bus.draw_wait       = (state == S_DRAW_WAIT);
    assign bus.erase_car       = (state == S_ERASE);
    assign bus.increment       = (state == S_INCREMENT);
    assign bus.destroyed_state = (state == S_DESTROYED);
    assign bus.car_active      = (state == S_DELAY) || kill_window;
    assign bus.state           = state;
endmodule

// File: tb/tb_car_controller.sv
// Directed bench for car_controller (MOVE_FRAMES=3): each scenario walks a
// table of {pulses, cycles, expected state} and checks state plus all strobes.
module tb_car_controller;
    localparam logic [7:0] P_START = 8'h01;
    localparam logic [7:0] P_TICK  = 8'h02;
    localparam logic [7:0] P_DEST  = 8'h04;
    localparam logic [7:0] P_IDD   = 8'h08;
    localparam logic [7:0] P_DD    = 8'h10;
    localparam logic [7:0] P_ED    = 8'h20;
    localparam logic [7:0] P_GO    = 8'h40;
    localparam logic [7:0] P_RST   = 8'h80;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    car_controller_if bus ();

    car_controller #(.MOVE_FRAMES(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    // Hand-written expected {wait_start, delay, draw_car, draw_wait, erase_car, increment, destroyed_state, car_active}.
    function automatic logic [7:0] exp_out(input logic [2:0] s);
        case (s)
            3'd0:    return 8'b1000_0000;
            3'd1:    return 8'b0100_0001;
            3'd2:    return 8'b0010_0001;
            3'd3:    return 8'b0001_0001;
            3'd4:    return 8'b0000_1001;
            3'd5:    return 8'b0000_0101;
            3'd6:    return 8'b0000_0010;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [7:0] obs_out();
        return {bus.wait_start, bus.delay, bus.draw_car, bus.draw_wait, bus.erase_car,
                bus.increment, bus.destroyed_state, bus.car_active};
    endfunction

    // Holds the given pulses for exactly one clock edge, then releases them.
    task automatic cycle(input logic [7:0] p);
        resetn                 = ~p[7];
        bus.start              = p[0];
        bus.frame_tick         = p[1];
        bus.destroyed          = p[2];
        bus.initial_delay_done = p[3];
        bus.draw_done          = p[4];
        bus.erase_done         = p[5];
        bus.game_over          = p[6];
        @(posedge clk);
        #1;
        resetn                 = 1'b1;
        bus.start              = 1'b0;
        bus.frame_tick         = 1'b0;
        bus.destroyed          = 1'b0;
        bus.initial_delay_done = 1'b0;
        bus.draw_done          = 1'b0;
        bus.erase_done         = 1'b0;
        bus.game_over          = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] stim [4] = '{P_RST | P_START, P_DEST, P_IDD | P_DD | P_ED | P_GO, P_TICK};
        logic [2:0] exp  [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
        for (int i = 0; i < 4; i++) begin
            cycle(stim[i]);
            checks += 2;
            if (bus.state !== exp[i]) begin
                errors++;
                $display("FAIL reset[%0d] state: got %0d expected %0d", i, bus.state, exp[i]);
            end
            if (obs_out() !== exp_out(exp[i])) begin
                errors++;
                $display("FAIL reset[%0d] strobes: got %b expected %b", i, obs_out(), exp_out(exp[i]));
            end
        end
    endtask

    task automatic test_launch();
        logic [7:0] stim [4] = '{P_START, P_IDD, P_START, P_DD};
        int         reps [4] = '{10, 5, 1, 1};
        logic [2:0] exp  [4] = '{3'd1, 3'd2, 3'd2, 3'd3};
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < reps[i]; r++) begin
                cycle(r == 0 ? stim[i] : 8'h00);
                checks += 2;
                if (bus.state !== exp[i]) begin
                    errors++;
                    $display("FAIL launch[%0d.%0d] state: got %0d expected %0d", i, r, bus.state, exp[i]);
                end
                if (obs_out() !== exp_out(exp[i])) begin
                    errors++;
                    $display("FAIL launch[%0d.%0d] strobes: got %b expected %b", i, r, obs_out(), exp_out(exp[i]));
                end
            end
        end
    endtask

    task automatic test_move();
        logic [7:0] stim [12] = '{P_TICK, P_TICK, P_TICK, 8'h00, P_ED, 8'h00,
                                  P_ED | P_START | P_IDD, P_DD, 8'h00, P_TICK, P_TICK, P_TICK};
        int         reps [12] = '{2, 2, 1, 2, 1, 1, 1, 1, 3, 1, 1, 1};
        logic [2:0] exp  [12] = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < reps[i]; r++) begin
                cycle(r == 0 ? stim[i] : 8'h00);
                checks += 2;
                if (bus.state !== exp[i]) begin
                    errors++;
                    $display("FAIL move[%0d.%0d] state: got %0d expected %0d", i, r, bus.state, exp[i]);
                end
                if (obs_out() !== exp_out(exp[i])) begin
                    errors++;
                    $display("FAIL move[%0d.%0d] strobes: got %b expected %b", i, r, obs_out(), exp_out(exp[i]));
                end
            end
        end
    endtask

    task automatic test_kill_in_draw();
        logic [7:0] stim [10] = '{P_ED, 8'h00, P_DEST, P_DD, 8'h00, 8'h00, P_ED, P_DEST | P_DD, P_START, 8'h00};
        logic [2:0] exp  [10] = '{3'd5, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd6, 3'd0, 3'd0};
        for (int i = 0; i < 10; i++) begin
            cycle(stim[i]);
            checks += 2;
            if (bus.state !== exp[i]) begin
                errors++;
                $display("FAIL kill_in_draw[%0d] state: got %0d expected %0d", i, bus.state, exp[i]);
            end
            if (obs_out() !== exp_out(exp[i])) begin
                errors++;
                $display("FAIL kill_in_draw[%0d] strobes: got %b expected %b", i, obs_out(), exp_out(exp[i]));
            end
        end
    endtask

    task automatic test_kill_in_delay();
        logic [7:0] stim [4] = '{P_START, P_DEST, P_IDD | P_DD | P_ED, P_START};
        logic [2:0] exp  [4] = '{3'd1, 3'd6, 3'd6, 3'd0};
        for (int i = 0; i < 4; i++) begin
            cycle(stim[i]);
            checks += 2;
            if (bus.state !== exp[i]) begin
                errors++;
                $display("FAIL kill_in_delay[%0d] state: got %0d expected %0d", i, bus.state, exp[i]);
            end
            if (obs_out() !== exp_out(exp[i])) begin
                errors++;
                $display("FAIL kill_in_delay[%0d] strobes: got %b expected %b", i, obs_out(), exp_out(exp[i]));
            end
        end
    endtask

    task automatic test_game_over();
        logic [7:0] stim [7] = '{P_START, P_IDD, P_DD, P_GO | P_DEST, P_DEST | P_TICK, P_ED, P_START};
        logic [2:0] exp  [7] = '{3'd1, 3'd2, 3'd3, 3'd7, 3'd7, 3'd7, 3'd0};
        for (int i = 0; i < 7; i++) begin
            cycle(stim[i]);
            checks += 2;
            if (bus.state !== exp[i]) begin
                errors++;
                $display("FAIL game_over[%0d] state: got %0d expected %0d", i, bus.state, exp[i]);
            end
            if (obs_out() !== exp_out(exp[i])) begin
                errors++;
                $display("FAIL game_over[%0d] strobes: got %b expected %b", i, obs_out(), exp_out(exp[i]));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] stim [14] = '{P_START, P_IDD, P_RST | P_DD, P_DD, P_START, P_IDD, P_DD,
                                  8'h00, P_TICK, P_TICK, P_TICK, P_RST | P_ED, P_ED, P_IDD};
        logic [2:0] exp  [14] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
                                  3'd3, 3'd3, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0};
        for (int i = 0; i < 14; i++) begin
            cycle(stim[i]);
            checks += 2;
            if (bus.state !== exp[i]) begin
                errors++;
                $display("FAIL reset_mid_op[%0d] state: got %0d expected %0d", i, bus.state, exp[i]);
            end
            if (obs_out() !== exp_out(exp[i])) begin
                errors++;
                $display("FAIL reset_mid_op[%0d] strobes: got %b expected %b", i, obs_out(), exp_out(exp[i]));
            end
        end
    endtask

    initial begin
        resetn                 = 1'b0;
        bus.start              = 1'b0;
        bus.frame_tick         = 1'b0;
        bus.destroyed          = 1'b0;
        bus.initial_delay_done = 1'b0;
        bus.draw_done          = 1'b0;
        bus.erase_done         = 1'b0;
        bus.game_over          = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_launch();
        test_move();
        test_kill_in_draw();
        test_kill_in_delay();
        test_game_over();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
